// File: rtl/mix_digest.sv
// mix_digest: folds an eight-lane 256-bit mixer snapshot into a 32-bit digest.
// One lane per cycle: acc = (rotl(acc, ROT) ^ lane[idx]) + idx + 1.
// The accumulator seed is SEED ^ out_count, so identical snapshots delivered
// at different positions in the stream give different digests.
module mix_digest #(
  parameter logic [31:0] SEED = 32'h0000_0000,
  parameter int unsigned ROT  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_digest,
  output logic [31:0]  out_count
);

  typedef enum logic [1:0] {IDLE, FOLD, HOLD} state_t;

  state_t         state_q, state_d;
  logic [255:0]   lanes_q, lanes_d;
  logic [2:0]     idx_q, idx_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    digest_q, digest_d;
  logic           vld_q, vld_d;
  logic [31:0]    cnt_q, cnt_d;

  logic           accept;
  logic           handshake;
  logic           last_step;
  logic [31:0]    lane;
  logic [31:0]    fold_acc;

  function automatic logic [31:0] rotl(input logic [31:0] x);
    return (x << ROT) | (x >> (32 - ROT));
  endfunction

  // Handshake qualifiers and the single fold step on the current lane.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    accept    = in_valid && in_ready;
    handshake = (state_q == HOLD) && out_ready;
    last_step = (state_q == FOLD) && (idx_q == 3'd7);
    lane      = lanes_q[{idx_q, 5'b0} +: 32];
    fold_acc  = (rotl(acc_q) ^ lane) + {29'd0, idx_q} + 32'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a HOLD handshake with a same-edge accept goes straight to FOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FOLD;
      FOLD:    if (idx_q == 3'd7) state_d = HOLD;
      HOLD:    if (handshake) state_d = accept ? FOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the seed uses the count after any same-edge increment.
  always_comb begin
    lanes_d  = lanes_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    digest_d = digest_q;
    vld_d    = vld_q;
    cnt_d    = handshake ? cnt_q + 32'd1 : cnt_q;
    if (handshake) vld_d = 1'b0;
    if (accept) begin
      lanes_d = in_data;
      idx_d   = 3'd0;
      acc_d   = SEED ^ cnt_d;
    end else if (state_q == FOLD) begin
      acc_d = fold_acc;
      idx_d = idx_q + 3'd1;
    end
    if (last_step) begin
      digest_d = fold_acc;
      vld_d    = 1'b1;
    end
  end

  // Datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q  <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      digest_q <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      lanes_q  <= lanes_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      digest_q <= digest_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_digest = digest_q;
  assign out_count  = cnt_q;

endmodule

// File: tb/tb_mix_digest.sv
// Directed bench for mix_digest (SEED=0, ROT=5).
module tb_mix_digest;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_digest;
  logic [31:0]  out_count;

  int checks   = 0;
  int failures = 0;

  mix_digest #(.SEED(32'h0000_0000), .ROT(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digest (out_digest),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  // Independent reference: rotate-left by 5 written as a concatenation.
  function automatic logic [31:0] model(input logic [31:0] seed, input logic [255:0] d);
    logic [31:0] a;
    a = seed;
    for (int i = 0; i < 8; i++) begin
      a = ({a[26:0], a[31:27]} ^ d[32*i +: 32]) + 32'(i + 1);
    end
    return a;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [255:0] vec [4];
  logic [255:0] ones;
  logic [31:0]  exp_dig;
  logic [31:0]  exp_cnt;
  logic [31:0]  held;

  initial begin
    vec[0] = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF_CAFE_BABE_0000_0001_8000_0000;
    vec[1] = 256'h1111_1111_2222_2222_3333_3333_4444_4444_5555_5555_6666_6666_7777_7777_8888_8888;
    vec[2] = 256'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0_0000_0000_FFFF_FFFF_1357_9BDF_2468_ACE0;
    vec[3] = 256'h8000_0001_7FFF_FFFE_C001_D00D_0BAD_F00D_1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    ones   = '1;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_digest", out_digest, 32'd0);
    chk("rst_count", out_count, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", {31'd0, in_ready}, 32'd1);

    // All-zero snapshot, 8-cycle latency, known digest
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fold_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (7) step();
    chk("zero_early_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("zero_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_digest", out_digest, 32'h8642_98F0);
    chk("zero_count_before", out_count, 32'd0);
    step();
    chk("zero_valid_clear", {31'd0, out_valid}, 32'd0);
    chk("zero_count_after", out_count, 32'd1);
    chk("zero_digest_kept", out_digest, 32'h8642_98F0);
    chk("zero_back_idle", {31'd0, in_ready}, 32'd1);

    // Backpressure: out_ready low for 20 cycles in HOLD
    out_ready = 1'b0; in_valid = 1'b1; in_data = ones;
    exp_dig = model(32'd1, ones);
    step();
    in_valid = 1'b0;
    repeat (8) step();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_digest", out_digest, exp_dig);
    held = out_digest;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_digest", out_digest, exp_dig);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_count", out_count, 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_count", out_count, 32'd2);
    step();
    chk("bp_single_hs", out_count, 32'd2);

    // Back-to-back stream with in_data scrambled during FOLD
    exp_cnt = 32'd2;
    in_valid = 1'b1; in_data = vec[0];
    for (int k = 0; k < 4; k++) begin
      if (k > 0) exp_cnt = exp_cnt + 32'd1;
      exp_dig = model(exp_cnt, vec[k]);
      step();
      for (int j = 1; j <= 8; j++) begin
        in_data = rand256();
        step();
        if (j < 8) begin
          chk("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
          chk("b2b_fold_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
          chk("b2b_valid", {31'd0, out_valid}, 32'd1);
          chk("b2b_digest", out_digest, exp_dig);
          chk("b2b_count", out_count, exp_cnt);
        end
      end
      if (k < 3) in_data = vec[k + 1];
      else       in_valid = 1'b0;
    end
    step();
    exp_cnt = exp_cnt + 32'd1;
    chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_end_count", out_count, exp_cnt);

    // Reset during FOLD step 4
    in_valid = 1'b1; in_data = vec[2];
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_digest", out_digest, 32'd0);
    chk("midrst_count", out_count, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("midrst_idle", {31'd0, in_ready}, 32'd1);
    chk("midrst_count_kept", out_count, 32'd0);

    // Count wrap from 2^32-1, seed follows the wrapped count
    force dut.cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.cnt_q;
    step();
    chk("wrap_preload", out_count, 32'hFFFF_FFFF);
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    exp_dig = model(32'hFFFF_FFFF, '0);
    step();
    repeat (8) step();
    chk("wrap_valid", {31'd0, out_valid}, 32'd1);
    chk("wrap_digest", out_digest, exp_dig);
    step();
    chk("wrap_count", out_count, 32'd0);
    chk("wrap_valid_clear", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    repeat (8) step();
    chk("wrap_next_valid", {31'd0, out_valid}, 32'd1);
    chk("wrap_next_digest", out_digest, 32'h8642_98F0);
    step();
    chk("wrap_next_count", out_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_digest.md
MIX_DIGEST -- requirements
Module: mix_digest

Interface
REQ-001 SHALL have parameter SEED, default 32'h0000_0000; initial accumulator value, XORed with the snapshot count.
REQ-002 SHALL have parameter ROT, default 5; left-rotate amount per fold step; legal range 1..31.
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit; upstream mixer snapshot is valid.
REQ-006 SHALL have port in_ready, output, 1 bit; the block can accept a snapshot.
REQ-007 SHALL have port in_data, input, 256 bits; eight 32-bit state words, lane k = in_data[32k+31:32k] (k = 0..7).
REQ-008 SHALL have port out_valid, output, 1 bit; the digest is valid.
REQ-009 SHALL have port out_ready, input, 1 bit; downstream accepts the digest.
REQ-010 SHALL have port out_digest, output, 32 bits; the folded digest.
REQ-011 SHALL have port out_count, output, 32 bits; the number of digests delivered so far.

Function
REQ-012 SHALL implement an FSM with states IDLE, FOLD and HOLD.
REQ-013 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready), combinationally.
REQ-014 SHALL treat an accept as in_valid && in_ready at a rising edge; on accept it SHALL do all of the following:
- latch all 256 bits of in_data;
- set idx = 0 and acc = SEED ^ out_count (the out_count value after any same-edge increment);
- enter FOLD.
REQ-015 SHALL, in FOLD, update once per cycle:
- acc = (rotl(acc, ROT) ^ lane[idx]) + idx + 1, modulo 2^32;
- idx = idx + 1.
REQ-016 SHALL make the FOLD step with idx = 7 the last one: load out_digest with the new acc, set out_valid = 1 and enter HOLD.
REQ-017 SHALL have a latency of 8 cycles: accept at edge E0, fold steps at E1..E8, out_valid high immediately after E8.
REQ-018 SHALL hold out_digest and out_valid stable in HOLD until out_valid && out_ready.
REQ-019 SHALL, on a HOLD handshake, increment out_count by 1 (2^32-1 wraps to 0) and clear out_valid.
- If no accept occurs on the same edge, the FSM SHALL enter IDLE.
REQ-020 SHALL, when the HOLD handshake and an accept occur on the same edge, complete both and enter FOLD directly.
- This gives back-to-back throughput of one digest per 9 cycles.
REQ-021 SHALL keep the latched lanes unaffected by in_data changes after the accept.
REQ-022 SHALL ignore in_valid while in FOLD (in_ready = 0 there).
REQ-023 SHALL hold out_digest at its last delivered value when out_valid is 0.

Reset
REQ-024 SHALL, while rst_n = 0, immediately set:
- state = IDLE, idx = 0, acc = 0, latched lanes = 0;
- out_valid = 0, out_digest = 0, out_count = 0.
REQ-025 SHALL, on reset asserted during FOLD or HOLD, abort the operation with no digest delivered and out_count left at 0.
REQ-026 SHALL leave the IDLE state on the first rising edge after rst_n deasserts only if in_valid = 1 on that edge.

Verification
REQ-027 SHALL cover: SEED=0, ROT=5, reset, one all-zero snapshot, out_ready = 1 -> out_valid high 8 cycles after accept, out_digest = 32'h864298F0, out_count 0 -> 1.
REQ-028 SHALL cover: out_ready held 0 for 20 cycles after out_valid -> digest stable, in_ready = 0, out_count unchanged; then out_ready = 1 -> one handshake.
REQ-029 SHALL cover: in_valid and out_ready held at 1 continuously -> a new accept on every HOLD handshake edge, out_valid pulses every 9 cycles, each digest matches the reference model.
REQ-030 SHALL cover: rst_n pulsed low at FOLD step 4 -> outputs are 0 immediately, with no out_valid until a new accept.
REQ-031 SHALL cover: out_count preloaded (via forced state) to 32'hFFFF_FFFF, one handshake -> out_count = 0 and the next acc seed = SEED ^ 0.
REQ-032 SHALL cover: in_data toggled randomly during FOLD -> digest equals the model result for the accepted snapshot only.
